// File: rtl/dbg_trap_trace_pkg.sv
// Shared types for the trap-event trace recorder.
package dbg_pkg;

    localparam int unsigned DBG_XLEN    = 64;
    localparam int unsigned DBG_CAUSE_W = 6;
    localparam int unsigned DBG_SEQ_W   = 16;

    localparam logic [15:0] OVF_MAX = 16'hFFFF;

    // Default-width entry layout; the top rebuilds the same layout from its own parameters.
    typedef struct packed {
        logic [DBG_XLEN-1:0]    pc;
        logic [DBG_CAUSE_W-1:0] cause;
        logic                   deleg;
        logic [DBG_XLEN-1:0]    tvec;
        logic [DBG_SEQ_W-1:0]   seq;
    } trace_entry_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        POST   = 2'd1,
        FROZEN = 2'd2
    } trig_state_e;

endpackage

// File: rtl/dbg_trap_trace_if.sv
// Trap-sample inputs and the valid/ready drain port of the trace recorder.
interface dbg_trap_trace_if #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned CAUSE_W = 6,
    parameter int unsigned SEQ_W   = 16
);
    logic [XLEN-1:0]    pc;
    logic               except;
    logic [CAUSE_W-1:0] cause;
    logic               medeleg;
    logic [XLEN-1:0]    tvec;

    logic               rd_valid;
    logic               rd_ready;
    logic [XLEN-1:0]    rd_pc;
    logic [CAUSE_W-1:0] rd_cause;
    logic               rd_deleg;
    logic [XLEN-1:0]    rd_tvec;
    logic [SEQ_W-1:0]   rd_seq;

    modport master (
        output pc, except, cause, medeleg, tvec, rd_ready,
        input  rd_valid, rd_pc, rd_cause, rd_deleg, rd_tvec, rd_seq
    );

    modport slave (
        input  pc, except, cause, medeleg, tvec, rd_ready,
        output rd_valid, rd_pc, rd_cause, rd_deleg, rd_tvec, rd_seq
    );
endinterface

// File: rtl/dbg_trap_trace_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
module dbg_trace_ram
    import dbg_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter type         entry_t = trace_entry_t
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  entry_t                   wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output entry_t                   rdata
);
    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/dbg_trap_trace.sv
// Trap-event trace recorder: overwrite-oldest circular buffer with cause trigger and freeze.
// Optional DBG_TRAP_DISPLAY_EN adds simulation-only event printing.
module dbg_trap_trace
    import dbg_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned CAUSE_W  = 6,
    parameter int unsigned POST_CNT = 4,
    parameter int unsigned SEQ_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    dbg_trap_trace_if.slave            bus,
    input  logic                       clear,
    input  logic                       freeze,
    input  logic                       trig_en,
    input  logic [CAUSE_W-1:0]         trig_cause,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [15:0]                overflow_cnt,
    output logic [1:0]                 state
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned PW = (POST_CNT > 0) ? $clog2(POST_CNT+1) : 1;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [CAUSE_W-1:0] cause;
        logic               deleg;
        logic [XLEN-1:0]    tvec;
        logic [SEQ_W-1:0]   seq;
    } entry_t;

    logic [AW-1:0]    wptr, rptr;
    logic [SEQ_W-1:0] seq;
    logic [PW-1:0]    post_cnt;
    trig_state_e      st;
    entry_t           wr_entry, rd_entry;
    logic             cap, pop, full, hit;

    assign full = (count == CW'(DEPTH));
    assign cap  = bus.except && (st != FROZEN) && !clear;
    assign pop  = bus.rd_valid && bus.rd_ready;
    assign hit  = trig_en && (bus.cause == trig_cause);

    assign wr_entry = '{pc: bus.pc, cause: bus.cause, deleg: bus.medeleg,
                        tvec: bus.tvec, seq: seq};

    dbg_trace_ram #(.DEPTH(DEPTH), .entry_t(entry_t)) u_ram (
        .clk   (clk),
        .we    (cap),
        .waddr (wptr),
        .wdata (wr_entry),
        .raddr (rptr),
        .rdata (rd_entry)
    );

    assign bus.rd_valid = (count != '0);
    assign bus.rd_pc    = rd_entry.pc;
    assign bus.rd_cause = rd_entry.cause;
    assign bus.rd_deleg = rd_entry.deleg;
    assign bus.rd_tvec  = rd_entry.tvec;
    assign bus.rd_seq   = rd_entry.seq;
    assign state        = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            overflow_cnt <= '0;
            seq          <= '0;
            post_cnt     <= '0;
            st           <= RUN;
        end else if (clear) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            overflow_cnt <= '0;
            seq          <= '0;
            post_cnt     <= '0;
            st           <= RUN;
        end else begin
            if (cap) begin
                wptr <= wptr + AW'(1);
                seq  <= seq + SEQ_W'(1);
            end
            // A full-buffer capture lands on rptr, so the oldest entry leaves exactly once
            // whether it was popped or overwritten.
            if (pop || (cap && full)) rptr <= rptr + AW'(1);
            if (cap && !pop && !full)      count <= count + CW'(1);
            else if (pop && !cap)          count <= count - CW'(1);
            if (cap && full && !pop && (overflow_cnt != OVF_MAX))
                overflow_cnt <= overflow_cnt + 16'd1;

            if (freeze) begin
                st <= FROZEN;
            end else begin
                case (st)
                    RUN: begin
                        if (cap && hit) begin
                            post_cnt <= PW'(POST_CNT);
                            if (POST_CNT == 0) st <= FROZEN;
                            else               st <= POST;
                        end
                    end
                    POST: begin
                        if (cap) begin
                            post_cnt <= post_cnt - PW'(1);
                            if (post_cnt == PW'(1)) st <= FROZEN;
                        end
                    end
                    FROZEN: ;
                    default: st <= RUN;
                endcase
            end
        end
    end

`ifdef DBG_TRAP_DISPLAY_EN
    function automatic logic check_verbose(input logic [XLEN-1:0] p);
        return 1'b1;
    endfunction
    trig_state_e st_d;
    always @(posedge clk) begin
        st_d <= st;
        if (rst_n) begin
            if (cap && check_verbose(bus.pc))
                $display($time,, "TRAP: [%08x] seq(%0d) cause(%0x) deleg(%0x) tvec(%0x)",
                         bus.pc, seq, bus.cause, bus.medeleg, bus.tvec);
            if (cap && full && !pop)
                $display($time,, "TRAP: overflow, entry seq(%0d) overwritten", rd_entry.seq);
            if (st == FROZEN && st_d != FROZEN)
                $display($time,, "TRAP: trace frozen, count(%0d)", count);
        end
    end
`endif
endmodule

// File: tb/tb_dbg_trap_trace.sv
// Directed bench for dbg_trap_trace: vector table plus hand-written multi-cycle sequences.
module tb_dbg_trap_trace;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0, freeze = 1'b0, trig_en = 1'b0;
    logic [5:0]  trig_cause = '0;
    logic [4:0]  count;
    logic [15:0] overflow_cnt;
    logic [1:0]  state;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    dbg_trap_trace_if #(.XLEN(64), .CAUSE_W(6), .SEQ_W(16)) bus ();

    dbg_trap_trace #(.XLEN(64), .DEPTH(16), .CAUSE_W(6), .POST_CNT(4), .SEQ_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .clear        (clear),
        .freeze       (freeze),
        .trig_en      (trig_en),
        .trig_cause   (trig_cause),
        .count        (count),
        .overflow_cnt (overflow_cnt),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock with the given inputs; outputs are settled 1 ns after the edge.
    task automatic cyc(input logic exc, input logic [63:0] p, input logic [5:0] c,
                       input logic rdy, input logic clr, input logic frz);
        bus.except   = exc;
        bus.pc       = p;
        bus.cause    = c;
        bus.medeleg  = p[2];
        bus.tvec     = p + 64'h100;
        bus.rd_ready = rdy;
        clear        = clr;
        freeze       = frz;
        @(posedge clk);
        #1;
        bus.except   = 1'b0;
        bus.rd_ready = 1'b0;
        clear        = 1'b0;
        freeze       = 1'b0;
    endtask

    typedef struct {
        logic        exc;
        logic [63:0] pc;
        logic        rdy;
        logic [4:0]  e_count;
        logic        e_valid;
        logic [15:0] e_seq;
        logic [63:0] e_pc;
    } vec_t;

    vec_t vecs [6];
    logic [5:0] tcause [7];
    logic [1:0] tstate [7];

    initial begin
        vecs[0] = '{1'b1, 64'h8000_0000, 1'b0, 5'd1, 1'b1, 16'd0, 64'h8000_0000};
        vecs[1] = '{1'b1, 64'h8000_0004, 1'b0, 5'd2, 1'b1, 16'd0, 64'h8000_0000};
        vecs[2] = '{1'b1, 64'h8000_0008, 1'b0, 5'd3, 1'b1, 16'd0, 64'h8000_0000};
        vecs[3] = '{1'b0, 64'h0,         1'b1, 5'd2, 1'b1, 16'd1, 64'h8000_0004};
        vecs[4] = '{1'b0, 64'h0,         1'b1, 5'd1, 1'b1, 16'd2, 64'h8000_0008};
        vecs[5] = '{1'b0, 64'h0,         1'b1, 5'd0, 1'b0, 16'd0, 64'h0};
        tcause = '{6'd2, 6'd8, 6'd2, 6'd2, 6'd2, 6'd2, 6'd2};
        tstate = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};

        bus.except = 1'b0; bus.pc = '0; bus.cause = '0; bus.medeleg = 1'b0;
        bus.tvec = '0; bus.rd_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_valid", 64'(bus.rd_valid), 64'd0);
        chk("reset_ovf", 64'(overflow_cnt), 64'd0);
        chk("reset_state", 64'(state), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: three captures then three pops
        for (int i = 0; i < 6; i++) begin
            cyc(vecs[i].exc, vecs[i].pc, 6'd2, vecs[i].rdy, 1'b0, 1'b0);
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_count));
            chk($sformatf("vec%0d_valid", i), 64'(bus.rd_valid), 64'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d_seq", i), 64'(bus.rd_seq), 64'(vecs[i].e_seq));
                chk($sformatf("vec%0d_pc", i), bus.rd_pc, vecs[i].e_pc);
                chk($sformatf("vec%0d_tvec", i), bus.rd_tvec, vecs[i].e_pc + 64'h100);
                chk($sformatf("vec%0d_deleg", i), 64'(bus.rd_deleg), 64'(vecs[i].e_pc[2]));
                chk($sformatf("vec%0d_cause", i), 64'(bus.rd_cause), 64'd2);
            end
        end

        // Overflow: 20 captures into 16 entries
        cyc(1'b0, 64'h0, 6'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 64'h1000 + 64'(4 * i), 6'd2, 1'b0, 1'b0, 1'b0);
        chk("ovf_count", 64'(count), 64'd16);
        chk("ovf_cnt", 64'(overflow_cnt), 64'd4);
        chk("ovf_head_seq", 64'(bus.rd_seq), 64'd4);
        chk("ovf_head_pc", bus.rd_pc, 64'h1010);

        // Full buffer: capture and pop together
        cyc(1'b1, 64'h1000 + 64'd80, 6'd2, 1'b1, 1'b0, 1'b0);
        chk("fullpop_count", 64'(count), 64'd16);
        chk("fullpop_ovf", 64'(overflow_cnt), 64'd4);
        chk("fullpop_head", 64'(bus.rd_seq), 64'd5);
        for (int s = 5; s <= 20; s++) begin
            chk($sformatf("drain_seq%0d", s), 64'(bus.rd_seq), 64'(s));
            chk($sformatf("drain_pc%0d", s), bus.rd_pc, 64'h1000 + 64'(4 * s));
            cyc(1'b0, 64'h0, 6'd0, 1'b1, 1'b0, 1'b0);
        end
        chk("drain_valid", 64'(bus.rd_valid), 64'd0);

        // Trigger with four post-trigger captures
        cyc(1'b0, 64'h0, 6'd0, 1'b0, 1'b1, 1'b0);
        trig_en = 1'b1;
        trig_cause = 6'd8;
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 64'h2000 + 64'(4 * i), tcause[i], 1'b0, 1'b0, 1'b0);
            chk($sformatf("trig_state%0d", i), 64'(state), 64'(tstate[i]));
        end
        chk("trig_count", 64'(count), 64'd6);
        cyc(1'b1, 64'h2100, 6'd8, 1'b0, 1'b0, 1'b0);
        chk("frozen_ignore", 64'(count), 64'd6);
        cyc(1'b0, 64'h0, 6'd0, 1'b1, 1'b0, 1'b0);
        chk("frozen_pop_count", 64'(count), 64'd5);
        chk("trig_entry_seq", 64'(bus.rd_seq), 64'd1);
        chk("trig_entry_cause", 64'(bus.rd_cause), 64'd8);
        trig_en = 1'b0;

        // Clear beats a same-cycle capture
        cyc(1'b1, 64'h3000, 6'd2, 1'b0, 1'b1, 1'b0);
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_ovf", 64'(overflow_cnt), 64'd0);
        chk("clr_state", 64'(state), 64'd0);
        cyc(1'b1, 64'h3000, 6'd2, 1'b0, 1'b0, 1'b0);
        chk("clr_next_seq", 64'(bus.rd_seq), 64'd0);
        chk("clr_next_pc", bus.rd_pc, 64'h3000);

        // Forced freeze still stores the same-cycle capture
        cyc(1'b1, 64'h3004, 6'd2, 1'b0, 1'b0, 1'b1);
        chk("frz_count", 64'(count), 64'd2);
        chk("frz_state", 64'(state), 64'd2);
        cyc(1'b1, 64'h3008, 6'd2, 1'b0, 1'b0, 1'b0);
        chk("frz_ignore", 64'(count), 64'd2);

        // Asynchronous reset mid-burst
        cyc(1'b0, 64'h0, 6'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 64'h4000 + 64'(4 * i), 6'd3, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_count", 64'(count), 64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(bus.rd_valid), 64'd0);
        chk("arst_state", 64'(state), 64'd0);
        chk("arst_ovf", 64'(overflow_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 64'h5000, 6'd2, 1'b0, 1'b0, 1'b0);
        chk("post_rst_seq", 64'(bus.rd_seq), 64'd0);
        chk("post_rst_count", 64'(count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
